pipelined_decode_ctrl: RTL and testbench

//  Registered ID-stage decoder: accepts IF/ID instructions via valid/ready and produces the ID/EX control bundle.

---
 rtl/ctrl_pkg.sv | 81 ++++++++
 rtl/imm_gen.sv | 34 +++
 rtl/pipelined_decode_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipelined_decode_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared decode constants, the bundle widths, and the opcode-to-control decode function.
// Unknown opcodes decode to an all-zero (NOP) control set.
package ctrl_pkg;

  localparam logic [4:0] OP_LW   = 5'b00000;
  localparam logic [4:0] OP_SW   = 5'b01000;
  localparam logic [4:0] OP_ADDI = 5'b00100;
  localparam logic [4:0] OP_R    = 5'b01100;
  localparam logic [4:0] OP_BEQ  = 5'b11000;
  localparam logic [4:0] OP_JAL  = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_CMP = 4'b1000;

  localparam int EX_W  = 6;
  localparam int MEM_W = 3;
  localparam int WB_W  = 2;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J
  } imm_sel_e;

  typedef struct packed {
    logic       alusrc;
    logic [3:0] aluop;
    logic       regdst;
    logic       jump;
    logic       branch;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       uses_rs1;
    logic       uses_rs2;
    imm_sel_e   imm_sel;
  } dec_t;

  function automatic logic op_known(input logic [4:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_ADDI) ||
           (op == OP_R) || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

  // r_aluop is {instr[30], funct3}; only R-type consumes it.
  function automatic dec_t decode_op(input logic [4:0] op, input logic [3:0] r_aluop);
    dec_t d;
    d = '0;
    case (op)
      OP_LW: begin
        d.alusrc = 1'b1; d.aluop = ALU_ADD; d.regdst = 1'b1;
        d.memtoreg = 1'b1; d.regwrite = 1'b1; d.memread = 1'b1;
        d.uses_rs1 = 1'b1; d.imm_sel = IMM_I;
      end
      OP_SW: begin
        d.alusrc = 1'b1; d.aluop = ALU_ADD; d.memwrite = 1'b1;
        d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.imm_sel = IMM_S;
      end
      OP_ADDI: begin
        d.alusrc = 1'b1; d.aluop = ALU_ADD; d.regdst = 1'b1; d.regwrite = 1'b1;
        d.uses_rs1 = 1'b1; d.imm_sel = IMM_I;
      end
      OP_R: begin
        d.aluop = r_aluop; d.regdst = 1'b1; d.regwrite = 1'b1;
        d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1;
      end
      OP_BEQ: begin
        d.aluop = ALU_CMP; d.branch = 1'b1;
        d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.imm_sel = IMM_B;
      end
      OP_JAL: begin
        d.jump = 1'b1; d.regdst = 1'b1; d.regwrite = 1'b1; d.imm_sel = IMM_J;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational I/S/B/J immediate extraction, each sign-extended from its top bit to XLEN.
// Takes instr[31:7] only; the opcode/size bits carry no immediate.
module imm_gen
  import ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:7]     instr_i,
  input  imm_sel_e        sel_i,
  output logic [XLEN-1:0] imm_o
);

  logic [11:0] i_imm;
  logic [11:0] s_imm;
  logic [12:0] b_imm;
  logic [20:0] j_imm;

  assign i_imm = instr_i[31:20];
  assign s_imm = {instr_i[31:25], instr_i[11:7]};
  assign b_imm = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign j_imm = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    imm_o = '0;
    case (sel_i)
      IMM_I:   imm_o = {{(XLEN-12){i_imm[11]}}, i_imm};
      IMM_S:   imm_o = {{(XLEN-12){s_imm[11]}}, s_imm};
      IMM_B:   imm_o = {{(XLEN-13){b_imm[12]}}, b_imm};
      IMM_J:   imm_o = {{(XLEN-21){j_imm[20]}}, j_imm};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/pipelined_decode_ctrl.sv
// Registered ID stage: IF/ID instruction in via valid/ready, ID/EX control bundle out one cycle later,
// with load-use stall, flush and a saturating stall counter. CTRL_ILLEGAL_TRAP_EN adds illegal-op flags.
module pipelined_decode_ctrl
  import ctrl_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [XLEN-1:0]  if_pc,
  output logic             id_ready,
  input  logic             ex_ready,
  input  logic             flush,
  output logic             id_valid,
  output logic [EX_W-1:0]  id_ex_ctrl,
  output logic [MEM_W-1:0] id_mem_ctrl,
  output logic [WB_W-1:0]  id_wb_ctrl,
  output logic             id_memread,
  output logic [XLEN-1:0]  id_imm,
  output logic [4:0]       id_rs1,
  output logic [4:0]       id_rs2,
  output logic [4:0]       id_rd,
  output logic [XLEN-1:0]  id_pc,
  output logic [CNT_W-1:0] stall_cnt
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic             id_illegal,
  output logic             illegal_seen
`endif
);

  typedef struct packed {
    logic             valid;
    logic [EX_W-1:0]  ex;
    logic [MEM_W-1:0] mem;
    logic [WB_W-1:0]  wb;
    logic             memread;
    logic [XLEN-1:0]  imm;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [XLEN-1:0]  pc;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic             illegal;
`endif
  } bundle_t;

  bundle_t          bndl_q, bndl_d, nxt;
  dec_t             dec;
  logic [XLEN-1:0]  imm;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;
  logic             load;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal;
  logic seen_q, seen_d;
`else
  logic unused_size_bits;
  assign unused_size_bits = ^if_instr[1:0];
`endif

  always_comb begin
    dec = decode_op(if_instr[6:2], {if_instr[30], if_instr[14:12]});
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal = ~op_known(if_instr[6:2]) | (if_instr[1:0] != 2'b11);
    if (illegal) dec = '0;
`endif
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i (if_instr[31:7]),
    .sel_i   (dec.imm_sel),
    .imm_o   (imm)
  );

  // Hazard looks only at the registered bundle, so a held (stalled) bundle keeps its verdict.
  assign hazard = bndl_q.valid & bndl_q.memread & (bndl_q.rd != 5'd0) &
                  (((bndl_q.rd == if_instr[19:15]) & dec.uses_rs1) |
                   ((bndl_q.rd == if_instr[24:20]) & dec.uses_rs2));

  assign id_ready = flush | ((~bndl_q.valid | ex_ready) & ~hazard);
  assign load     = if_valid & id_ready & ~flush;

  always_comb begin
    nxt         = '0;
    nxt.valid   = 1'b1;
    nxt.ex      = {dec.alusrc, dec.aluop, dec.regdst};
    nxt.mem     = {dec.jump, dec.branch, dec.memwrite};
    nxt.wb      = {dec.memtoreg, dec.regwrite};
    nxt.memread = dec.memread;
    nxt.imm     = imm;
    nxt.rs1     = if_instr[19:15];
    nxt.rs2     = if_instr[24:20];
    nxt.rd      = if_instr[11:7];
    nxt.pc      = if_pc;
`ifdef CTRL_ILLEGAL_TRAP_EN
    nxt.illegal = illegal;
`endif
  end

  always_comb begin
    bndl_d = bndl_q;
    cnt_d  = cnt_q;
    if (flush)         bndl_d = '0;
    else if (load)     bndl_d = nxt;
    else if (ex_ready) bndl_d = '0;
    if (hazard & if_valid & ~flush & ~(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign seen_d = seen_q | (load & illegal);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) seen_q <= 1'b0;
    else     seen_q <= seen_d;
  end

  assign id_illegal   = bndl_q.illegal;
  assign illegal_seen = seen_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bndl_q <= '0;
      cnt_q  <= '0;
    end else begin
      bndl_q <= bndl_d;
      cnt_q  <= cnt_d;
    end
  end

  assign id_valid    = bndl_q.valid;
  assign id_ex_ctrl  = bndl_q.ex;
  assign id_mem_ctrl = bndl_q.mem;
  assign id_wb_ctrl  = bndl_q.wb;
  assign id_memread  = bndl_q.memread;
  assign id_imm      = bndl_q.imm;
  assign id_rs1      = bndl_q.rs1;
  assign id_rs2      = bndl_q.rs2;
  assign id_rd       = bndl_q.rd;
  assign id_pc       = bndl_q.pc;
  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_pipelined_decode_ctrl.sv
// Directed bench for pipelined_decode_ctrl; exercises CTRL_ILLEGAL_TRAP_EN paths when that macro is defined.
module tb_pipelined_decode_ctrl;
  localparam int XLEN  = 64;
  localparam int CNT_W = 8;

  localparam logic [31:0] I_LW   = 32'h0080A283; // lw   x5, 8(x1)
  localparam logic [31:0] I_ADD  = 32'h00228333; // add  x6, x5, x2
  localparam logic [31:0] I_SW   = 32'hFE20AE23; // sw   x2, -4(x1)
  localparam logic [31:0] I_BEQ  = 32'hFE208CE3; // beq  x1, x2, -8
  localparam logic [31:0] I_ADDI = 32'hFFF00193; // addi x3, x0, -1
  localparam logic [31:0] I_JAL  = 32'h001000EF; // jal  x1, +0x800
  localparam logic [31:0] I_SUB  = 32'h402083B3; // sub  x7, x1, x2
  localparam logic [31:0] I_UNK  = 32'h0000007F; // opcode[6:2]=11111

  logic             clk = 1'b0;
  logic             rst, if_valid, ex_ready, flush, id_ready, id_valid, id_memread;
  logic [31:0]      if_instr;
  logic [XLEN-1:0]  if_pc, id_imm, id_pc;
  logic [5:0]       id_ex_ctrl;
  logic [2:0]       id_mem_ctrl;
  logic [1:0]       id_wb_ctrl;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic [CNT_W-1:0] stall_cnt;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic             id_illegal, illegal_seen;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pipelined_decode_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush), .id_valid(id_valid),
    .id_ex_ctrl(id_ex_ctrl), .id_mem_ctrl(id_mem_ctrl), .id_wb_ctrl(id_wb_ctrl),
    .id_memread(id_memread), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_pc(id_pc), .stall_cnt(stall_cnt)
`ifdef CTRL_ILLEGAL_TRAP_EN
    , .id_illegal(id_illegal), .illegal_seen(illegal_seen)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [XLEN-1:0] pc,
                       input logic er, input logic fl);
    if_valid = v;
    if_instr = ins;
    if_pc    = pc;
    ex_ready = er;
    flush    = fl;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, '0, 1'b1, 1'b0);
    tick;
    tick;
    chk("rst_valid", id_valid, 0);
    chk("rst_ready", id_ready, 1);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_imm", id_imm, 0);
    chk("rst_ex", id_ex_ctrl, 0);
    rst = 1'b0;

    // Load-use: LW x5 then ADD using x5 -> one bubble
    drive(1'b1, I_LW, 64'h100, 1'b1, 1'b0);
    tick;
    chk("lw_valid", id_valid, 1);
    chk("lw_ex", id_ex_ctrl, 6'b100001);
    chk("lw_wb", id_wb_ctrl, 2'b11);
    chk("lw_memread", id_memread, 1);
    chk("lw_imm", id_imm, 64'd8);
    chk("lw_rd", id_rd, 5);
    chk("lw_rs1", id_rs1, 1);
    chk("lw_pc", id_pc, 64'h100);
    drive(1'b1, I_ADD, 64'h104, 1'b1, 1'b0);
    #1;
    chk("hz_ready", id_ready, 0);
    tick;
    chk("bubble_valid", id_valid, 0);
    chk("bubble_cnt", stall_cnt, 1);
    chk("bubble_ready", id_ready, 1);
    tick;
    chk("add_valid", id_valid, 1);
    chk("add_ex", id_ex_ctrl, 6'b000001);
    chk("add_rd", id_rd, 6);
    chk("add_rs2", id_rs2, 2);
    chk("add_imm", id_imm, 0);
    chk("add_pc", id_pc, 64'h104);
    chk("add_cnt", stall_cnt, 1);

    drive(1'b1, I_SW, 64'h108, 1'b1, 1'b0);
    tick;
    chk("sw_imm", id_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("sw_mem", id_mem_ctrl, 3'b001);
    chk("sw_wb", id_wb_ctrl, 2'b00);
    chk("sw_ex", id_ex_ctrl, 6'b100000);
    chk("sw_memread", id_memread, 0);

    drive(1'b1, I_BEQ, 64'h10C, 1'b1, 1'b0);
    tick;
    chk("beq_imm", id_imm, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("beq_ex", id_ex_ctrl, 6'b010000);
    chk("beq_mem", id_mem_ctrl, 3'b010);
    chk("beq_wb", id_wb_ctrl, 2'b00);

    drive(1'b1, I_ADDI, 64'h110, 1'b1, 1'b0);
    tick;
    chk("addi_imm", id_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_ex", id_ex_ctrl, 6'b100001);
    chk("addi_wb", id_wb_ctrl, 2'b01);
    chk("addi_rd", id_rd, 3);

    drive(1'b1, I_JAL, 64'h114, 1'b1, 1'b0);
    tick;
    chk("jal_imm", id_imm, 64'h800);
    chk("jal_mem", id_mem_ctrl, 3'b100);
    chk("jal_wb", id_wb_ctrl, 2'b01);
    chk("jal_ex", id_ex_ctrl, 6'b000001);
    drive(1'b1, I_ADDI, 64'h118, 1'b0, 1'b1);
    #1;
    chk("flush_ready", id_ready, 1);
    tick;
    chk("flush_valid", id_valid, 0);
    drive(1'b0, I_ADDI, 64'h118, 1'b1, 1'b0);
    #1;
    chk("postflush_ready", id_ready, 1);

    // Backpressure: R-type held for three cycles
    drive(1'b1, I_SUB, 64'h200, 1'b1, 1'b0);
    tick;
    chk("sub_ex", id_ex_ctrl, 6'b010001);
    drive(1'b1, I_ADDI, 64'h204, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("hold_valid", id_valid, 1);
      chk("hold_ex", id_ex_ctrl, 6'b010001);
      chk("hold_rd", id_rd, 7);
      chk("hold_pc", id_pc, 64'h200);
      chk("hold_ready", id_ready, 0);
      chk("hold_cnt", stall_cnt, 1);
    end
    ex_ready = 1'b1;
    tick;
    chk("release_rd", id_rd, 3);
    chk("release_pc", id_pc, 64'h204);

    drive(1'b1, I_UNK, 64'h208, 1'b1, 1'b0);
    tick;
    chk("nop_valid", id_valid, 1);
    chk("nop_ex", id_ex_ctrl, 0);
    chk("nop_mem", id_mem_ctrl, 0);
    chk("nop_wb", id_wb_ctrl, 0);
    chk("nop_imm", id_imm, 0);

    // Held load-use hazard drives the counter into saturation
    drive(1'b1, I_LW, 64'h300, 1'b1, 1'b0);
    tick;
    drive(1'b1, I_ADD, 64'h304, 1'b0, 1'b0);
    for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
      tick;
      if (i == 9) chk("cnt_mid", stall_cnt, 11);
    end
    chk("cnt_sat", stall_cnt, 8'hFF);
    chk("sat_valid", id_valid, 1);
    chk("sat_pc", id_pc, 64'h300);

    #2 rst = 1'b1;
    #1;
    chk("arst_valid", id_valid, 0);
    chk("arst_cnt", stall_cnt, 0);
    chk("arst_imm", id_imm, 0);
    chk("arst_pc", id_pc, 0);
    chk("arst_ex", id_ex_ctrl, 0);
    chk("arst_wb", id_wb_ctrl, 0);
    chk("arst_memread", id_memread, 0);
    chk("arst_ready", id_ready, 1);

`ifdef CTRL_ILLEGAL_TRAP_EN
    tick;
    rst = 1'b0;
    drive(1'b1, 32'h0, 64'h400, 1'b1, 1'b0);
    tick;
    chk("ill_flag", id_illegal, 1);
    chk("ill_seen", illegal_seen, 1);
    chk("ill_ex", id_ex_ctrl, 0);
    drive(1'b1, I_ADDI, 64'h404, 1'b1, 1'b0);
    tick;
    chk("ill_clear", id_illegal, 0);
    chk("ill_sticky", illegal_seen, 1);
    rst = 1'b1;
    #1;
    chk("ill_rst", illegal_seen, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
